nibble_sequencer: RTL

- Instruction fetch/decode/control FSM for the 4-bit CPU; it drives every control input of the 4-bit datapath and consumes the datapath's take_branch flag.
- Fetches 8-bit instructions as two nibbles from a combinational program ROM and holds an 8-bit PC.
- Decodes a small ISA and asserts datapath control for exactly one EXEC cycle per instruction.

---
 rtl/nibble_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/nibble_sequencer.sv
// ============================================================================
// Module  : nibble_sequencer
// Brief   : Fetch/decode/control FSM for the 4-bit CPU. Fetches 8-bit
//           instructions as two nibbles from a combinational ROM, keeps the
//           PC and drives the datapath control strobes for one EXEC cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          data_i,
  input  logic                take_branch_i,
  output logic [PC_WIDTH:0]   rom_addr_o,
  output logic                sync_o,
  output logic                halt_o,
  output logic [3:0]          inst_operand_o,
  output logic                clear_carry_o,
  output logic                write_carry_o,
  output logic                clear_accumulator_o,
  output logic                write_accumulator_o,
  output logic                write_register_o,
  output logic [2:0]          acc_input_sel_o,
  output logic [1:0]          reg_input_sel_o,
  output logic [1:0]          alu_op_o,
  output logic [2:0]          alu_in0_sel_o,
  output logic [1:0]          alu_in1_sel_o,
  output logic [1:0]          alu_cin_sel_o
);

  localparam logic [2:0] FETCH_OPR = 3'd0;
  localparam logic [2:0] FETCH_OPA = 3'd1;
  localparam logic [2:0] EXEC      = 3'd2;
  localparam logic [2:0] ADDR_HI   = 3'd3;
  localparam logic [2:0] ADDR_LO   = 3'd4;
  localparam logic [2:0] BRANCH    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          opr_q, opr_d;
  logic [3:0]          opa_q, opa_d;
  logic [7:0]          tgt_q, tgt_d;
  logic                halt_q, halt_d;

  // Two-byte instructions carry their target in the byte after the opcode.
  logic [PC_WIDTH-1:0] pc_inc;
  logic                is_jump;
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign is_jump = (opr_q == 4'h1) || (opr_q == 4'h4);

  // State and datapath registers; synchronous reset to the fetch of address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH_OPR;
      pc_q    <= '0;
      opr_q   <= '0;
      opa_q   <= '0;
      tgt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      tgt_q   <= tgt_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state logic; everything holds while halted.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    tgt_d   = tgt_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        FETCH_OPR: begin
          opr_d   = data_i;
          state_d = FETCH_OPA;
        end
        FETCH_OPA: begin
          opa_d   = data_i;
          state_d = EXEC;
        end
        EXEC: begin
          if (is_jump) begin
            state_d = ADDR_HI;
          end else begin
            pc_d    = pc_inc;
            state_d = FETCH_OPR;
            if ((opr_q == 4'h0) && (opa_q == 4'h1)) halt_d = 1'b1;
          end
        end
        ADDR_HI: begin
          tgt_d[7:4] = data_i;
          state_d    = ADDR_LO;
        end
        ADDR_LO: begin
          tgt_d[3:0] = data_i;
          state_d    = BRANCH;
        end
        BRANCH: begin
          // JUN always jumps; JCN jumps only on the datapath condition.
          if ((opr_q == 4'h4) || take_branch_i) pc_d = PC_WIDTH'(tgt_q);
          else                                  pc_d = pc_q + PC_WIDTH'(2);
          state_d = FETCH_OPR;
        end
        default: state_d = FETCH_OPR;
      endcase
    end
  end

  // Output decode: ROM address per fetch phase, controls only in EXEC.
  always_comb begin
    rom_addr_o          = {pc_q, 1'b0};
    sync_o              = (state_q == FETCH_OPR);
    halt_o              = halt_q;
    inst_operand_o      = opa_q;
    clear_carry_o       = 1'b0;
    write_carry_o       = 1'b0;
    clear_accumulator_o = 1'b0;
    write_accumulator_o = 1'b0;
    write_register_o    = 1'b0;
    acc_input_sel_o     = 3'd0;
    reg_input_sel_o     = 2'd0;
    alu_op_o            = 2'd0;
    alu_in0_sel_o       = 3'd0;
    alu_in1_sel_o       = 2'd0;
    alu_cin_sel_o       = 2'd0;

    case (state_q)
      FETCH_OPA: rom_addr_o = {pc_q, 1'b1};
      ADDR_HI:   rom_addr_o = {pc_inc, 1'b0};
      ADDR_LO:   rom_addr_o = {pc_inc, 1'b1};
      default:   rom_addr_o = {pc_q, 1'b0};
    endcase

    // A reset arriving in EXEC must not let a write through.
    if ((state_q == EXEC) && !halt_q && !reset) begin
      case (opr_q)
        4'h6: begin  // INC
          write_register_o = 1'b1;
          reg_input_sel_o  = 2'd1;
          alu_in0_sel_o    = 3'd1;
          alu_in1_sel_o    = 2'd1;
          alu_cin_sel_o    = 2'd2;
        end
        4'h8: begin  // ADD
          write_accumulator_o = 1'b1;
          acc_input_sel_o     = 3'd2;
          write_carry_o       = 1'b1;
        end
        4'h9: begin  // SUB
          write_accumulator_o = 1'b1;
          acc_input_sel_o     = 3'd2;
          write_carry_o       = 1'b1;
          alu_op_o            = 2'd1;
          alu_cin_sel_o       = 2'd3;
        end
        4'hA: write_accumulator_o = 1'b1;  // LD
        4'hB: begin  // XCH
          write_accumulator_o = 1'b1;
          write_register_o    = 1'b1;
        end
        4'hD: begin  // LDM
          write_accumulator_o = 1'b1;
          acc_input_sel_o     = 3'd3;
        end
        4'hF: begin
          case (opa_q)
            4'h0: begin  // CLB
              clear_accumulator_o = 1'b1;
              clear_carry_o       = 1'b1;
            end
            4'h1: clear_carry_o = 1'b1;  // CLC
            4'h2: begin  // IAC
              write_accumulator_o = 1'b1;
              acc_input_sel_o     = 3'd2;
              write_carry_o       = 1'b1;
              alu_in1_sel_o       = 2'd1;
              alu_cin_sel_o       = 2'd2;
            end
            4'h3: begin  // TCC
              write_accumulator_o = 1'b1;
              acc_input_sel_o     = 3'd4;
              clear_carry_o       = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
